mem_rd_arbiter: RTL and testbench
=================================

# mem_rd_arbiter

Two-requester AXI read arbiter sitting between the prefetcher's memory-side read port (`prefetcherTop` m_ar/m_r) plus one secondary read requester and a single shared `axi_ram` read port. Arbitrates AR requests round-robin through a registered output stage. Tracks issue order in an in-order source FIFO, and routes each R burst back to the requester that issued it. This relies on the memory returning read bursts in issue order, which `axi_ram` does.

## Interface
Parameters:
- `ADDR_BITS`, 64: address width.
- `BURST_LEN_WIDTH`, 8: AR len width.
- `TID_WIDTH`, 8: AXI ID width.
- `LOG_BLOCK_DATA_BYTES`, 0: data width is `8<<LOG_BLOCK_DATA_BYTES` bits.
- `LOG_OUTSTANDING`, 3: source FIFO depth is `1<<LOG_OUTSTANDING` outstanding bursts.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `s0_ar_valid`, `s0_ar_ready`  in/out  1  requester 0 AR handshake. Requester 0 is the prefetcher.
- `s0_ar_addr`/`s0_ar_len`/`s0_ar_id`  in  ADDR_BITS/BURST_LEN_WIDTH/TID_WIDTH  requester 0 AR payload.
- `s1_ar_valid`, `s1_ar_ready`, `s1_ar_addr`, `s1_ar_len`, `s1_ar_id`  same as s0, for requester 1.
- `m_ar_valid`  out  1, `m_ar_ready`  in  1, `m_ar_addr`/`m_ar_len`/`m_ar_id`  out  AR to memory.
- `m_r_valid`  in  1, `m_r_ready`  out  1, `m_r_last`  in  1, `m_r_data`  in  DATA, `m_r_id`  in  TID_WIDTH  R from memory.
- `s0_r_valid`  out  1, `s0_r_ready`  in  1, `s0_r_last`/`s0_r_data`/`s0_r_id`  out  R to requester 0.
- `s1_r_*`  same as s0, for requester 1.
- `outstandingCnt`  out  LOG_OUTSTANDING+1  bursts accepted but not yet completed (last beat returned).
- `errUnexpectedR`  out  1  sticky; set when an R beat arrives while no burst is outstanding.

## Operation
- Output stage: `m_ar_*` are registers. `stageFree = ~m_ar_valid | m_ar_ready`.
- Grant:
  - If only one requester is valid, it is granted.
  - If both are valid, the requester not granted last wins.
  - `lastGrant` resets to 1, so s0 wins the first tie.
- `sN_ar_ready = grantN & stageFree & ~fifoFull`. Ready is never asserted to a requester that is not valid.
- Accept (`sN_ar_valid & sN_ar_ready`):
  - Load `m_ar_addr/len/id` from requester N.
  - Set `m_ar_valid`.
  - Push N into the source FIFO.
  - Update `lastGrant = N`.
- On `m_ar_valid & m_ar_ready` with no accept in the same cycle, clear `m_ar_valid`.
- The ID is passed through unmodified; the ID is not used for routing.
- R routing, combinational; the FIFO head `h` selects the destination:
  - `sH_r_valid = m_r_valid & ~fifoEmpty`.
  - The other requester's `r_valid` is 0.
  - Data, last and id are broadcast to both requesters.
  - `m_r_ready = sH_r_ready` when non-empty.
- Pop on `m_r_valid & m_r_ready & m_r_last`.
- Empty FIFO with `m_r_valid`:
  - `m_r_ready = 1`, so the beat is drained and dropped.
  - `errUnexpectedR` is set.
  - Both `s*_r_valid` stay 0.
- `outstandingCnt` = FIFO occupancy, range 0..`1<<LOG_OUTSTANDING`.
  - Push and pop in the same cycle leave the count unchanged.
  - A push is allowed when full only if a pop occurs in the same cycle? No: `fifoFull` blocks the push regardless, to avoid a combinational ready-from-R path.

## Timing
- Reset values:
  - `m_ar_valid = 0`, `m_ar_addr/len/id = 0`.
  - FIFO empty, `outstandingCnt = 0`, `errUnexpectedR = 0`, `lastGrant = 1`.
  - All `s*_ar_ready = 0`.
  - `s*_r_valid = 0` while reset is asserted.
- AR latency: accept at edge k gives `m_ar_valid = 1` after edge k, holding until `m_ar_ready`.
- Back-to-back throughput is 1 AR/cycle when `m_ar_ready` is held high.
- AR payload is stable while `m_ar_valid & ~m_ar_ready`.
- R path adds zero latency: it is combinational from `m_r_*`/`sN_r_ready`.
- The FIFO pointer is updated at the edge where the last beat handshakes; the next burst routes from the following cycle.
- The FIFO pointers wrap modulo depth. Full/empty are derived from `outstandingCnt`.
- Reset mid-burst:
  - All state clears asynchronously.
  - Beats arriving after reset count as unexpected; they are drained and flagged.

## Structure
- Shared package `prefetcher_pkg`: `src_t` (1-bit source enum `SRC_PR = 0`, `SRC_EXT = 1`), and the grant helper function.
- One sub-module: `src_order_fifo`. It is a parametric 1-bit-wide sync FIFO with push, pop, full, empty and count outputs, and an async active-high reset.

## Test plan
- Single request: s0 `addr = 0xdeadbeef`, `len = 3`, `id = 5`, `m_ar_ready = 1`.
  - Expect: `m_ar_valid` one cycle later with the same payload; `outstandingCnt = 1`.
  - The 4 R beats are seen only on `s0_r`.
  - After the last beat, `outstandingCnt = 0`.
- Tie: s0 and s1 valid continuously with `m_ar_ready = 1`.
  - Expect: grants s0, s1, s0, s1.
  - R bursts return to s0, s1, s0, s1 in that order.
- Backpressure: `m_ar_ready = 0` for 5 cycles.
  - Expect: `m_ar_*` stable, both `s*_ar_ready = 0`.
  - On release, the next grant is accepted in the same cycle.
- Full: 8 accepts with no R beats returned.
  - Expect: `outstandingCnt = 8`, all `ar_ready = 0`.
  - One burst completes, then exactly one new accept occurs.
- R backpressure: s1 head burst with `s1_r_ready = 0`.
  - Expect: `m_r_ready = 0`, `s0_r_valid = 0`.
- Unexpected R beat with an empty FIFO.
  - Expect: `m_r_ready = 1`, `errUnexpectedR = 1` (sticky until `rst`).

Source files
------------

// File: rtl/prefetcher_pkg.sv
// Shared types and helpers for the prefetcher memory-side read path.
package prefetcher_pkg;

  // Which requester issued a burst: the prefetcher or the external secondary port.
  typedef enum logic {
    SRC_PR  = 1'b0,
    SRC_EXT = 1'b1
  } src_t;

  // Round-robin pick between two requesters; on a tie the one not granted last wins.
  function automatic src_t pick_grant(input logic v0, input logic v1, input src_t last_grant);
    if (v0 && v1) begin
      return (last_grant == SRC_PR) ? SRC_EXT : SRC_PR;
    end else if (v1) begin
      return SRC_EXT;
    end else begin
      return SRC_PR;
    end
  endfunction

endpackage

// File: rtl/src_order_fifo.sv
// In-order record of which requester issued each outstanding read burst.
module src_order_fifo #(
  parameter int unsigned LOG_DEPTH = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               push_data,
  input  logic               pop,
  output logic               head,
  output logic               full,
  output logic               empty,
  output logic [LOG_DEPTH:0] count
);

  localparam int unsigned DEPTH = 1 << LOG_DEPTH;

  logic [DEPTH-1:0]     mem_q;
  logic [LOG_DEPTH-1:0] wr_ptr_q;
  logic [LOG_DEPTH-1:0] rd_ptr_q;
  logic [LOG_DEPTH:0]   count_q;
  logic                 do_push;
  logic                 do_pop;

  assign full    = (count_q == (LOG_DEPTH + 1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Storage, wrapping pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mem_rd_arbiter.sv
// Two-requester AXI read arbiter: round-robin AR through a register stage,
// R bursts routed back in issue order via a source FIFO.
module mem_rd_arbiter
  import prefetcher_pkg::*;
#(
  parameter int unsigned ADDR_BITS            = 64,
  parameter int unsigned BURST_LEN_WIDTH      = 8,
  parameter int unsigned TID_WIDTH            = 8,
  parameter int unsigned LOG_BLOCK_DATA_BYTES = 0,
  parameter int unsigned LOG_OUTSTANDING      = 3
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  s0_ar_valid,
  output logic                                  s0_ar_ready,
  input  logic [ADDR_BITS-1:0]                  s0_ar_addr,
  input  logic [BURST_LEN_WIDTH-1:0]            s0_ar_len,
  input  logic [TID_WIDTH-1:0]                  s0_ar_id,
  input  logic                                  s1_ar_valid,
  output logic                                  s1_ar_ready,
  input  logic [ADDR_BITS-1:0]                  s1_ar_addr,
  input  logic [BURST_LEN_WIDTH-1:0]            s1_ar_len,
  input  logic [TID_WIDTH-1:0]                  s1_ar_id,
  output logic                                  m_ar_valid,
  input  logic                                  m_ar_ready,
  output logic [ADDR_BITS-1:0]                  m_ar_addr,
  output logic [BURST_LEN_WIDTH-1:0]            m_ar_len,
  output logic [TID_WIDTH-1:0]                  m_ar_id,
  input  logic                                  m_r_valid,
  output logic                                  m_r_ready,
  input  logic                                  m_r_last,
  input  logic [(8<<LOG_BLOCK_DATA_BYTES)-1:0]  m_r_data,
  input  logic [TID_WIDTH-1:0]                  m_r_id,
  output logic                                  s0_r_valid,
  input  logic                                  s0_r_ready,
  output logic                                  s0_r_last,
  output logic [(8<<LOG_BLOCK_DATA_BYTES)-1:0]  s0_r_data,
  output logic [TID_WIDTH-1:0]                  s0_r_id,
  output logic                                  s1_r_valid,
  input  logic                                  s1_r_ready,
  output logic                                  s1_r_last,
  output logic [(8<<LOG_BLOCK_DATA_BYTES)-1:0]  s1_r_data,
  output logic [TID_WIDTH-1:0]                  s1_r_id,
  output logic [LOG_OUTSTANDING:0]              outstandingCnt,
  output logic                                  errUnexpectedR
);

  src_t last_grant_q;
  src_t grant;
  logic stage_free;
  logic fifo_full;
  logic fifo_empty;
  logic fifo_head;
  logic acc0;
  logic acc1;
  logic fifo_pop;

  // AR side: grant, readies and accepts.
  always_comb begin
    grant       = pick_grant(s0_ar_valid, s1_ar_valid, last_grant_q);
    stage_free  = ~m_ar_valid | m_ar_ready;
    // Readies held low during reset so nothing is accepted into a clearing stage.
    s0_ar_ready = ~rst & s0_ar_valid & (grant == SRC_PR) & stage_free & ~fifo_full;
    s1_ar_ready = ~rst & s1_ar_valid & (grant == SRC_EXT) & stage_free & ~fifo_full;
    acc0        = s0_ar_valid & s0_ar_ready;
    acc1        = s1_ar_valid & s1_ar_ready;
  end

  // Registered AR output stage and round-robin history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ar_valid   <= 1'b0;
      m_ar_addr    <= '0;
      m_ar_len     <= '0;
      m_ar_id      <= '0;
      last_grant_q <= SRC_EXT;
    end else if (acc0) begin
      m_ar_valid   <= 1'b1;
      m_ar_addr    <= s0_ar_addr;
      m_ar_len     <= s0_ar_len;
      m_ar_id      <= s0_ar_id;
      last_grant_q <= SRC_PR;
    end else if (acc1) begin
      m_ar_valid   <= 1'b1;
      m_ar_addr    <= s1_ar_addr;
      m_ar_len     <= s1_ar_len;
      m_ar_id      <= s1_ar_id;
      last_grant_q <= SRC_EXT;
    end else if (m_ar_ready) begin
      m_ar_valid <= 1'b0;
    end
  end

  // R routing: FIFO head picks the destination; an empty FIFO drains stray beats.
  always_comb begin
    s0_r_last  = m_r_last;
    s0_r_data  = m_r_data;
    s0_r_id    = m_r_id;
    s1_r_last  = m_r_last;
    s1_r_data  = m_r_data;
    s1_r_id    = m_r_id;
    s0_r_valid = m_r_valid & ~fifo_empty & ~fifo_head;
    s1_r_valid = m_r_valid & ~fifo_empty & fifo_head;
    if (fifo_empty) begin
      m_r_ready = 1'b1;
    end else begin
      m_r_ready = fifo_head ? s1_r_ready : s0_r_ready;
    end
    fifo_pop = m_r_valid & m_r_ready & m_r_last & ~fifo_empty;
  end

  // Sticky flag for R beats with no outstanding burst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      errUnexpectedR <= 1'b0;
    end else if (m_r_valid && fifo_empty) begin
      errUnexpectedR <= 1'b1;
    end
  end

  src_order_fifo #(
    .LOG_DEPTH (LOG_OUTSTANDING)
  ) u_src_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (acc0 | acc1),
    .push_data (acc1),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (outstandingCnt)
  );

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Directed bench for mem_rd_arbiter; the bench acts as both requesters and memory.
module tb_mem_rd_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        s0_ar_valid, s0_ar_ready, s1_ar_valid, s1_ar_ready;
  logic [63:0] s0_ar_addr, s1_ar_addr, m_ar_addr;
  logic [7:0]  s0_ar_len, s1_ar_len, m_ar_len;
  logic [7:0]  s0_ar_id, s1_ar_id, m_ar_id;
  logic        m_ar_valid, m_ar_ready;
  logic        m_r_valid, m_r_ready, m_r_last;
  logic [7:0]  m_r_data, m_r_id;
  logic        s0_r_valid, s0_r_ready, s0_r_last;
  logic [7:0]  s0_r_data, s0_r_id;
  logic        s1_r_valid, s1_r_ready, s1_r_last;
  logic [7:0]  s1_r_data, s1_r_id;
  logic [3:0]  outstandingCnt;
  logic        errUnexpectedR;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  mem_rd_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .s0_ar_valid    (s0_ar_valid),
    .s0_ar_ready    (s0_ar_ready),
    .s0_ar_addr     (s0_ar_addr),
    .s0_ar_len      (s0_ar_len),
    .s0_ar_id       (s0_ar_id),
    .s1_ar_valid    (s1_ar_valid),
    .s1_ar_ready    (s1_ar_ready),
    .s1_ar_addr     (s1_ar_addr),
    .s1_ar_len      (s1_ar_len),
    .s1_ar_id       (s1_ar_id),
    .m_ar_valid     (m_ar_valid),
    .m_ar_ready     (m_ar_ready),
    .m_ar_addr      (m_ar_addr),
    .m_ar_len       (m_ar_len),
    .m_ar_id        (m_ar_id),
    .m_r_valid      (m_r_valid),
    .m_r_ready      (m_r_ready),
    .m_r_last       (m_r_last),
    .m_r_data       (m_r_data),
    .m_r_id         (m_r_id),
    .s0_r_valid     (s0_r_valid),
    .s0_r_ready     (s0_r_ready),
    .s0_r_last      (s0_r_last),
    .s0_r_data      (s0_r_data),
    .s0_r_id        (s0_r_id),
    .s1_r_valid     (s1_r_valid),
    .s1_r_ready     (s1_r_ready),
    .s1_r_last      (s1_r_last),
    .s1_r_data      (s1_r_data),
    .s1_r_id        (s1_r_id),
    .outstandingCnt (outstandingCnt),
    .errUnexpectedR (errUnexpectedR)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    s0_ar_valid = 0; s0_ar_addr = '0; s0_ar_len = '0; s0_ar_id = '0;
    s1_ar_valid = 0; s1_ar_addr = '0; s1_ar_len = '0; s1_ar_id = '0;
    m_ar_ready  = 1; m_r_valid = 0; m_r_last = 0; m_r_data = '0; m_r_id = '0;
    s0_r_ready  = 1; s1_r_ready = 1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    rst = 0;
    settle();
  endtask

  initial begin
    logic exp_g;
    idle_inputs();
    rst = 1;

    // Reset: outputs clear and nothing is accepted or routed even with activity on inputs.
    tick();
    s0_ar_valid = 1; m_r_valid = 1;
    tick();
    chk("rst_m_ar_valid", m_ar_valid, 0);
    chk("rst_m_ar_addr", m_ar_addr, 0);
    chk("rst_cnt", outstandingCnt, 0);
    chk("rst_err", errUnexpectedR, 0);
    chk("rst_s0_ar_ready", s0_ar_ready, 0);
    chk("rst_s0_r_valid", s0_r_valid, 0);
    do_reset();

    // Single request from s0.
    s0_ar_valid = 1; s0_ar_addr = 64'hdeadbeef; s0_ar_len = 3; s0_ar_id = 5;
    settle();
    chk("single_s0_ready", s0_ar_ready, 1);
    tick();
    s0_ar_valid = 0;
    chk("single_m_valid", m_ar_valid, 1);
    chk("single_m_addr", m_ar_addr, 64'hdeadbeef);
    chk("single_m_len", m_ar_len, 3);
    chk("single_m_id", m_ar_id, 5);
    chk("single_cnt1", outstandingCnt, 1);
    tick();
    chk("single_m_valid_clr", m_ar_valid, 0);
    for (int i = 0; i < 4; i++) begin
      m_r_valid = 1; m_r_data = 8'(8'h10 + i); m_r_last = (i == 3); m_r_id = 5;
      settle();
      chk("single_r_s0_valid", s0_r_valid, 1);
      chk("single_r_s1_valid", s1_r_valid, 0);
      chk("single_r_data", s0_r_data, 64'(8'h10 + i));
      chk("single_r_ready", m_r_ready, 1);
      tick();
    end
    m_r_valid = 0; m_r_last = 0;
    chk("single_cnt0", outstandingCnt, 0);

    // Tie: alternating grants starting with s0 after reset.
    do_reset();
    s0_ar_valid = 1; s0_ar_addr = 64'h100;
    s1_ar_valid = 1; s1_ar_addr = 64'h200;
    for (int i = 0; i < 4; i++) begin
      exp_g = i[0];
      settle();
      chk("tie_s0_ready", s0_ar_ready, !exp_g);
      chk("tie_s1_ready", s1_ar_ready, exp_g);
      tick();
      chk("tie_m_addr", m_ar_addr, exp_g ? 64'h200 : 64'h100);
    end
    s0_ar_valid = 0; s1_ar_valid = 0;
    chk("tie_cnt4", outstandingCnt, 4);
    for (int i = 0; i < 4; i++) begin
      exp_g = i[0];
      m_r_valid = 1; m_r_last = 1;
      settle();
      chk("tie_r_s0_valid", s0_r_valid, !exp_g);
      chk("tie_r_s1_valid", s1_r_valid, exp_g);
      tick();
    end
    m_r_valid = 0; m_r_last = 0;
    chk("tie_cnt0", outstandingCnt, 0);

    // AR backpressure: stage holds, nobody gets ready, release grants same cycle.
    do_reset();
    s0_ar_valid = 1; s0_ar_addr = 64'haaa0;
    tick();
    m_ar_ready = 0;
    s0_ar_addr = 64'hbbb0;
    s1_ar_valid = 1; s1_ar_addr = 64'hccc0;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("bp_s0_ready", s0_ar_ready, 0);
      chk("bp_s1_ready", s1_ar_ready, 0);
      chk("bp_m_addr", m_ar_addr, 64'haaa0);
      chk("bp_m_valid", m_ar_valid, 1);
      tick();
    end
    m_ar_ready = 1;
    settle();
    chk("bp_release_s1_ready", s1_ar_ready, 1);
    tick();
    s0_ar_valid = 0; s1_ar_valid = 0;
    chk("bp_release_addr", m_ar_addr, 64'hccc0);
    chk("bp_cnt", outstandingCnt, 2);

    // Full: eight accepts, then exactly one more after one burst completes.
    do_reset();
    s0_ar_valid = 1;
    for (int i = 0; i < 8; i++) begin
      s0_ar_addr = 64'(i);
      tick();
    end
    settle();
    chk("full_cnt8", outstandingCnt, 8);
    chk("full_s0_ready", s0_ar_ready, 0);
    m_r_valid = 1; m_r_last = 1;
    settle();
    chk("full_pop_r_ready", m_r_ready, 1);
    chk("full_pop_s0_ready", s0_ar_ready, 0);
    tick();
    m_r_valid = 0; m_r_last = 0;
    settle();
    chk("full_cnt7", outstandingCnt, 7);
    chk("full_s0_ready_again", s0_ar_ready, 1);
    tick();
    settle();
    chk("full_cnt8_again", outstandingCnt, 8);
    chk("full_s0_ready_blocked", s0_ar_ready, 0);
    s0_ar_valid = 0;

    // R backpressure on an s1 head burst.
    do_reset();
    s1_ar_valid = 1; s1_ar_addr = 64'h55;
    tick();
    s1_ar_valid = 0;
    m_r_valid = 1; m_r_last = 1; s1_r_ready = 0; s0_r_ready = 1;
    settle();
    chk("rbp_m_r_ready", m_r_ready, 0);
    chk("rbp_s0_r_valid", s0_r_valid, 0);
    chk("rbp_s1_r_valid", s1_r_valid, 1);
    tick();
    chk("rbp_cnt_held", outstandingCnt, 1);
    s1_r_ready = 1;
    settle();
    chk("rbp_m_r_ready_rel", m_r_ready, 1);
    tick();
    m_r_valid = 0; m_r_last = 0;
    chk("rbp_cnt0", outstandingCnt, 0);
    chk("rbp_no_err", errUnexpectedR, 0);

    // Unexpected R beat with an empty FIFO: drained, flagged, sticky until reset.
    m_r_valid = 1; m_r_last = 0;
    settle();
    chk("unexp_m_r_ready", m_r_ready, 1);
    chk("unexp_s0_r_valid", s0_r_valid, 0);
    chk("unexp_s1_r_valid", s1_r_valid, 0);
    tick();
    m_r_valid = 0;
    chk("unexp_err_set", errUnexpectedR, 1);
    tick();
    tick();
    chk("unexp_err_sticky", errUnexpectedR, 1);
    chk("unexp_cnt", outstandingCnt, 0);
    do_reset();
    chk("unexp_err_cleared", errUnexpectedR, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Guard against a hang in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, required finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
